// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Cause/Status bit positions and
// reset constants used by the CP0 timer/compare logic.
package cp0_pkg;

    // CP0 register numbers (rd field of mtc0/mfc0)
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;

    // Bit positions inside Cause
    localparam logic [4:0] CAUSE_TI  = 5'd30;
    localparam logic [4:0] CAUSE_IP7 = 5'd15;

    // Reset values of Count and Compare
    localparam logic [31:0] COUNT_RST = 32'h0000_0001;
    localparam logic [31:0] CMP_RST   = 32'h0000_0000;

endpackage

// File: rtl/cp0_match_edge.sv
// Count/Compare equality detector with rising-edge qualification: a match
// that persists for several cycles produces a single set pulse.
module cp0_match_edge #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_cmp,
    output logic             o_set
);

    logic w_match;
    logic r_match_prev;

    assign w_match = (i_count == i_cmp);

    // Remember last cycle's equality so a held match is only seen once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_prev <= 1'b0;
        end else begin
            r_match_prev <= w_match;
        end
    end

    assign o_set = w_match & ~r_match_prev;

endmodule

// File: rtl/cp0_timer_compare.sv
// CP0 Compare register and timer-interrupt (Cause.TI / IP7) generator.
// Optional feature macro: CP0_TIMER_AUTORELOAD_EN adds a period register that
// advances Compare by the period on each timer event.
module cp0_timer_compare
    import cp0_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] CMP_RST = WIDTH'(cp0_pkg::CMP_RST)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count_q,
    input  logic             count_we,
    input  logic             cmp_we,
    input  logic [WIDTH-1:0] cmp_wd,
    input  logic             period_we,
    input  logic [WIDTH-1:0] period_wd,
    input  logic             irq_en,
    output logic [WIDTH-1:0] cmp_q,
    output logic             ti,
    output logic             timer_irq
);

    logic [WIDTH-1:0] r_cmp;
    logic             r_ti;
    logic [WIDTH-1:0] w_cmp_nxt;
    logic             w_ti_nxt;
    logic             w_set;
    logic             w_unused;

    // A Count write has no direct effect here: a new Count value that equals
    // Compare is caught by the edge detector like any other match.
`ifdef CP0_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] r_period;

    assign w_unused = count_we;
`else
    assign w_unused = ^{count_we, period_we, period_wd};
`endif

    cp0_match_edge #(
        .WIDTH (WIDTH)
    ) u_match_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_count (count_q),
        .i_cmp   (r_cmp),
        .o_set   (w_set)
    );

    // Next Compare/TI: a software Compare write beats a simultaneous timer event
    always_comb begin
        w_cmp_nxt = r_cmp;
        w_ti_nxt  = r_ti;
        if (cmp_we) begin
            w_cmp_nxt = cmp_wd;
            w_ti_nxt  = 1'b0;
        end else if (w_set) begin
            w_ti_nxt = 1'b1;
`ifdef CP0_TIMER_AUTORELOAD_EN
            if (r_period != {WIDTH{1'b0}}) begin
                w_cmp_nxt = r_cmp + r_period;
            end else begin
                w_cmp_nxt = r_cmp;
            end
`endif
        end else begin
            w_cmp_nxt = r_cmp;
            w_ti_nxt  = r_ti;
        end
    end

    // Compare and pending-TI state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp <= CMP_RST;
            r_ti  <= 1'b0;
        end else begin
            r_cmp <= w_cmp_nxt;
            r_ti  <= w_ti_nxt;
        end
    end

`ifdef CP0_TIMER_AUTORELOAD_EN
    // Auto-reload period, written by software
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= {WIDTH{1'b0}};
        end else if (period_we) begin
            r_period <= period_wd;
        end else begin
            r_period <= r_period;
        end
    end
`endif

    assign cmp_q     = r_cmp;
    assign ti        = r_ti;
    // Status gating only masks the request; TI stays visible for polling
    assign timer_irq = r_ti & irq_en;

endmodule

// File: tb/tb_cp0_timer_compare.sv
// Self-checking bench for cp0_timer_compare: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// Compare/TI rules. Honours CP0_TIMER_AUTORELOAD_EN when defined.
module tb_cp0_timer_compare;

    logic        clk;
    logic        rst_n;
    logic [31:0] count_q;
    logic        count_we;
    logic        cmp_we;
    logic [31:0] cmp_wd;
    logic        period_we;
    logic [31:0] period_wd;
    logic        irq_en;
    logic [31:0] cmp_q;
    logic        ti;
    logic        timer_irq;

    int n_chk;
    int n_err;

    // Reference model state
    logic [31:0] m_cmp;
    logic        m_ti;
    logic        m_was_equal;
    logic [31:0] m_period;

    // Bench-side Count register
    logic [31:0] cnt;

    cp0_timer_compare #(
        .WIDTH   (32),
        .CMP_RST (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_q   (count_q),
        .count_we  (count_we),
        .cmp_we    (cmp_we),
        .cmp_wd    (cmp_wd),
        .period_we (period_we),
        .period_wd (period_wd),
        .irq_en    (irq_en),
        .cmp_q     (cmp_q),
        .ti        (ti),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check comb irq, advance model, check registers
    task automatic cycle(input logic [31:0] c, input logic cwe, input logic [31:0] cwd,
                         input logic pwe, input logic [31:0] pwd, input logic ien);
        logic hit;
        count_q   = c;
        count_we  = 1'b0;
        cmp_we    = cwe;
        cmp_wd    = cwd;
        period_we = pwe;
        period_wd = pwd;
        irq_en    = ien;
        #1;
        check_eq("timer_irq", {31'd0, timer_irq}, {31'd0, m_ti & ien});
        // Timer event: Count newly equal to Compare this cycle
        hit = (c == m_cmp) && !m_was_equal;
        m_was_equal = (c == m_cmp);
        if (cwe) begin
            m_cmp = cwd;
            m_ti  = 1'b0;
        end else if (hit) begin
            m_ti = 1'b1;
`ifdef CP0_TIMER_AUTORELOAD_EN
            if (m_period != 32'd0) m_cmp = m_cmp + m_period;
`endif
        end
`ifdef CP0_TIMER_AUTORELOAD_EN
        if (pwe) m_period = pwd;
`endif
        @(posedge clk);
        #1;
        check_eq("ti", {31'd0, ti}, {31'd0, m_ti});
        check_eq("cmp_q", cmp_q, m_cmp);
        @(negedge clk);
    endtask

    // Let Count run freely for n cycles
    task automatic run(input int n, input logic ien);
        for (int i = 0; i < n; i++) begin
            cycle(cnt, 1'b0, 32'd0, 1'b0, 32'd0, ien);
            cnt = cnt + 32'd1;
        end
    endtask

    // Compare write while Count keeps running
    task automatic write_cmp(input logic [31:0] v, input logic ien);
        cycle(cnt, 1'b1, v, 1'b0, 32'd0, ien);
        cnt = cnt + 32'd1;
    endtask

    // Asynchronous reset in mid-operation; release at a negedge
    task automatic do_reset(input logic [31:0] cnt_at_release);
        @(negedge clk);
        irq_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_cmp_q", cmp_q, 32'h0000_0000);
        check_eq("rst_ti", {31'd0, ti}, 32'd0);
        check_eq("rst_irq", {31'd0, timer_irq}, 32'd0);
        m_cmp = 32'h0000_0000;
        m_ti = 1'b0;
        m_was_equal = 1'b0;
        m_period = 32'd0;
        cmp_we = 1'b0;
        period_we = 1'b0;
        count_q = cnt_at_release;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = cnt_at_release;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        count_q = 32'd1;
        count_we = 1'b0;
        cmp_we = 1'b0;
        cmp_wd = 32'd0;
        period_we = 1'b0;
        period_wd = 32'd0;
        irq_en = 1'b1;
        cnt = 32'd1;
        m_cmp = 32'd0;
        m_ti = 1'b0;
        m_was_equal = 1'b0;
        m_period = 32'd0;

        // Power-up: Count from 1, Compare 0 -> no interrupt
        do_reset(32'd1);
        run(100, 1'b1);
        check_eq("pwrup_ti", {31'd0, ti}, 32'd0);
        check_eq("pwrup_cmp", cmp_q, 32'd0);

        // Compare 0x20, Count passes through it, irq_en toggled
        cnt = 32'h10;
        write_cmp(32'h20, 1'b1);
        run(16, 1'b1);
        run(4, 1'b0);
        run(4, 1'b1);
        check_eq("ti_held", {31'd0, ti}, 32'd1);

        // Rewrite Compare clears TI; new match sets it again
        write_cmp(32'h40, 1'b1);
        check_eq("ti_clr", {31'd0, ti}, 32'd0);
        run(30, 1'b1);
        check_eq("ti_reset_again", {31'd0, ti}, 32'd1);

        // Compare write in the same cycle as a timer event
        write_cmp(32'h50, 1'b1);
        cnt = 32'h4E;
        run(2, 1'b1);
        cycle(cnt, 1'b1, 32'h60, 1'b0, 32'd0, 1'b1);
        cnt = cnt + 32'd1;
        check_eq("coll_ti", {31'd0, ti}, 32'd0);
        check_eq("coll_cmp", cmp_q, 32'h60);

        // Count held at 0x30 by repeated writes, Compare rewritten mid-hold
        write_cmp(32'h30, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(32'h30, i == 2, 32'h30, 1'b0, 32'd0, 1'b1);
        end
        check_eq("hold_ti", {31'd0, ti}, 32'd0);
        cnt = 32'h31;
        run(3, 1'b1);

        // Count wraps to 0 and matches Compare=0
        write_cmp(32'h0, 1'b1);
        cnt = 32'hFFFF_FFFD;
        run(5, 1'b1);
        check_eq("wrap_ti", {31'd0, ti}, 32'd1);

`ifdef CP0_TIMER_AUTORELOAD_EN
        // Periodic reload of Compare
        cycle(cnt, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1);
        cnt = 32'h08;
        run(12, 1'b1);
        check_eq("reload1", cmp_q, 32'h20);
        run(16, 1'b1);
        check_eq("reload2", cmp_q, 32'h30);
        write_cmp(32'hFFFF_FFF8, 1'b1);
        cnt = 32'hFFFF_FFF0;
        run(12, 1'b1);
        check_eq("reload_wrap", cmp_q, 32'h0000_0008);
`endif

        // Reset mid-run with Count equal to the reset Compare at release
        do_reset(32'd0);
        run(3, 1'b1);
        check_eq("rel_ti", {31'd0, ti}, 32'd1);

        // Randomized traffic with Compare kept close to Count
        for (int i = 0; i < 600; i++) begin
            int r;
            logic cwe;
            logic pwe;
            logic [31:0] cwd;
            logic [31:0] pwd;
            r   = $urandom_range(0, 99);
            cwe = (r < 10);
            cwd = cnt + 32'($urandom_range(0, 12));
            pwe = ($urandom_range(0, 99) < 4);
            pwd = 32'($urandom_range(0, 8));
            cycle(cnt, cwe, cwd, pwe, pwd, 1'($urandom_range(0, 1)));
            r = $urandom_range(0, 99);
            if (r < 5) begin
                cnt = cnt - 32'($urandom_range(0, 6));
            end else if (r < 12) begin
                cnt = cnt;
            end else begin
                cnt = cnt + 32'd1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
